// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_pkg
// Description : Shared widths and enumerations for the branch resolution
//               stage (branch type encoding and FSM state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

  localparam int PC_W  = 10;
  localparam int IDX_W = 4;

  // Branch condition encoding as presented by the decode stage
  typedef enum logic [1:0] {
    BR_FLAG   = 2'b00,
    BR_NFLAG  = 2'b01,
    BR_ALWAYS = 2'b10,
    BR_NEVER  = 2'b11
  } br_type_t;

  // Resolution FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    FLUSH   = 2'd2
  } br_state_t;

endpackage : branch_pkg
`default_nettype wire

// File: rtl/branch_lut.sv
`default_nettype none
// ============================================================================
// Module      : branch_lut
// Description : Programmable jump-target table. Flop array with asynchronous
//               clear, one synchronous write port and one combinational read
//               port. A same-cycle write to the read index returns old data.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_lut #(
  parameter int PC_W      = 10,
  parameter int LUT_DEPTH = 16,
  parameter int IDX_W     = 4
) (
  input  logic             CLK,
  input  logic             Init,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [PC_W-1:0]  wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [PC_W-1:0]  rdata
);

  logic [PC_W-1:0] r_mem [LUT_DEPTH];

  generate
    for (genvar gi = 0; gi < LUT_DEPTH; gi++) begin : g_entry
      // One table entry: cleared on Init, loaded when its index is written
      always_ff @(posedge CLK or posedge Init) begin
        if (Init) begin
          r_mem[gi] <= '0;
        end else if (we && (waddr == IDX_W'(gi))) begin
          r_mem[gi] <= wdata;
        end
      end
    end
  endgenerate

  // Combinational read of the pre-edge contents
  assign rdata = r_mem[raddr];

endmodule : branch_lut
`default_nettype wire

// File: rtl/branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_unit
// Description : Branch resolution stage feeding the fetch stage. Holds the
//               condition flag and the jump-target table, resolves each
//               accepted branch one cycle later on registered outputs, and
//               raises Flush for two cycles after a taken branch.
//               Optional feature macro: BRANCH_STATS_EN adds the saturating
//               Taken_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_unit #(
  parameter int PC_W      = 10,
  parameter int LUT_DEPTH = 16,
  parameter int IDX_W     = 4
) (
  input  logic             CLK,
  input  logic             Init,
  input  logic             Flag_we,
  input  logic             Flag_d,
  input  logic             Br_req,
  input  logic [1:0]       Br_type,
  input  logic [IDX_W-1:0] Br_idx,
  input  logic             Lut_we,
  input  logic [IDX_W-1:0] Lut_waddr,
  input  logic [PC_W-1:0]  Lut_wdata,
  input  logic             Halt,
`ifdef BRANCH_STATS_EN
  output logic [15:0]      Taken_cnt,
`endif
  output logic             Branch_en,
  output logic             FLAG_IN,
  output logic [PC_W-1:0]  Target,
  output logic             Flush
);

  import branch_pkg::*;

  br_state_t       r_state;
  br_state_t       w_state_nxt;
  logic            r_flag;
  logic            r_branch_en;
  logic            r_flag_in;
  logic            r_flush;
  logic [PC_W-1:0] r_target;
  logic            w_branch_en_nxt;
  logic            w_flag_in_nxt;
  logic            w_flush_nxt;
  logic [PC_W-1:0] w_target_nxt;
  logic            w_eff_flag;
  logic            w_taken;
  logic            w_accept;
  logic [PC_W-1:0] w_lut_rdata;

  branch_lut #(
    .PC_W      (PC_W),
    .LUT_DEPTH (LUT_DEPTH),
    .IDX_W     (IDX_W)
  ) u_lut (
    .CLK   (CLK),
    .Init  (Init),
    .we    (Lut_we),
    .waddr (Lut_waddr),
    .wdata (Lut_wdata),
    .raddr (Br_idx),
    .rdata (w_lut_rdata)
  );

  // Condition flag written by the ALU
  always_ff @(posedge CLK or posedge Init) begin
    if (Init) begin
      r_flag <= 1'b0;
    end else if (Flag_we) begin
      r_flag <= Flag_d;
    end
  end

  // A flag written in the same cycle as the branch is used directly
  assign w_eff_flag = Flag_we ? Flag_d : r_flag;

  // Evaluate the branch condition for the incoming request
  always_comb begin
    w_taken = 1'b0;
    case (br_type_t'(Br_type))
      BR_FLAG:   w_taken = w_eff_flag;
      BR_NFLAG:  w_taken = !w_eff_flag;
      BR_ALWAYS: w_taken = 1'b1;
      BR_NEVER:  w_taken = 1'b0;
      default:   w_taken = 1'b0;
    endcase
  end

  // Next state and next registered outputs; taken-ness in RESOLVE is r_flag_in
  always_comb begin
    w_state_nxt     = r_state;
    w_accept        = 1'b0;
    w_branch_en_nxt = 1'b0;
    w_flag_in_nxt   = 1'b0;
    w_flush_nxt     = 1'b0;
    w_target_nxt    = r_target;
    case (r_state)
      IDLE: begin
        if (Br_req && !Halt) w_accept = 1'b1;
      end
      RESOLVE: begin
        if (r_flag_in) begin
          w_state_nxt = FLUSH;
          w_flush_nxt = 1'b1;
        end else if (Br_req && !Halt) begin
          w_accept = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      FLUSH: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (w_accept) begin
      w_state_nxt     = RESOLVE;
      w_branch_en_nxt = 1'b1;
      w_flag_in_nxt   = w_taken;
      w_flush_nxt     = w_taken;
      w_target_nxt    = w_lut_rdata;
    end
  end

  // State register and registered outputs
  always_ff @(posedge CLK or posedge Init) begin
    if (Init) begin
      r_state     <= IDLE;
      r_branch_en <= 1'b0;
      r_flag_in   <= 1'b0;
      r_flush     <= 1'b0;
      r_target    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_branch_en <= w_branch_en_nxt;
      r_flag_in   <= w_flag_in_nxt;
      r_flush     <= w_flush_nxt;
      r_target    <= w_target_nxt;
    end
  end

  assign Branch_en = r_branch_en;
  assign FLAG_IN   = r_flag_in;
  assign Flush     = r_flush;
  assign Target    = r_target;

`ifdef BRANCH_STATS_EN
  logic [15:0] r_taken_cnt;

  // Saturating count of taken resolutions
  always_ff @(posedge CLK or posedge Init) begin
    if (Init) begin
      r_taken_cnt <= '0;
    end else if ((r_state == RESOLVE) && r_flag_in && (r_taken_cnt != 16'hFFFF)) begin
      r_taken_cnt <= r_taken_cnt + 16'd1;
    end
  end

  assign Taken_cnt = r_taken_cnt;
`endif

endmodule : branch_unit
`default_nettype wire

// File: tb/tb_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_unit
// Description : Directed self-checking bench for branch_unit. Outputs are
//               compared as {Branch_en, FLAG_IN, Flush, Target}.
//               Optional feature macro: BRANCH_STATS_EN enables the
//               Taken_cnt scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_unit;

  logic       CLK = 1'b0;
  logic       Init;
  logic       Flag_we, Flag_d, Br_req, Lut_we, Halt;
  logic [1:0] Br_type;
  logic [3:0] Br_idx, Lut_waddr;
  logic [9:0] Lut_wdata;
  logic       Branch_en, FLAG_IN, Flush;
  logic [9:0] Target;
`ifdef BRANCH_STATS_EN
  logic [15:0] Taken_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  branch_unit dut (
    .CLK       (CLK),
    .Init      (Init),
    .Flag_we   (Flag_we),
    .Flag_d    (Flag_d),
    .Br_req    (Br_req),
    .Br_type   (Br_type),
    .Br_idx    (Br_idx),
    .Lut_we    (Lut_we),
    .Lut_waddr (Lut_waddr),
    .Lut_wdata (Lut_wdata),
    .Halt      (Halt),
`ifdef BRANCH_STATS_EN
    .Taken_cnt (Taken_cnt),
`endif
    .Branch_en (Branch_en),
    .FLAG_IN   (FLAG_IN),
    .Target    (Target),
    .Flush     (Flush)
  );

  always #5 CLK = ~CLK;

  // Advance to 1 ns after the next rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    Flag_we = 0; Flag_d = 0; Br_req = 0; Br_type = 2'b11; Br_idx = 0;
    Lut_we = 0; Lut_waddr = 0; Lut_wdata = 0; Halt = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Init = 1;
    step();
    checks++;
    if ({Branch_en, FLAG_IN, Flush, Target} !== 13'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=%h", {Branch_en, FLAG_IN, Flush, Target}, 13'h0);
    end
    Init = 0;
    step();
  endtask

  task automatic test_taken_flag();
    Lut_we = 1; Lut_waddr = 3; Lut_wdata = 10'h1A5; Flag_we = 1; Flag_d = 1;
    step();
    Lut_we = 0; Flag_we = 0; Br_req = 1; Br_type = 2'b00; Br_idx = 3;
    step();
    Br_req = 0;
    checks++;
    if ({Branch_en, FLAG_IN, Flush, Target} !== {3'b111, 10'h1A5}) begin
      failures++;
      $display("FAIL taken_resolve got=%h want=%h", {Branch_en, FLAG_IN, Flush, Target}, {3'b111, 10'h1A5});
    end
    step();
    checks++;
    if ({Branch_en, FLAG_IN, Flush, Target} !== {3'b001, 10'h1A5}) begin
      failures++;
      $display("FAIL taken_flush got=%h want=%h", {Branch_en, FLAG_IN, Flush, Target}, {3'b001, 10'h1A5});
    end
    step();
    checks++;
    if ({Branch_en, FLAG_IN, Flush, Target} !== {3'b000, 10'h1A5}) begin
      failures++;
      $display("FAIL taken_idle got=%h want=%h", {Branch_en, FLAG_IN, Flush, Target}, {3'b000, 10'h1A5});
    end
  endtask

  task automatic test_flag_bypass();
    Flag_we = 1; Flag_d = 0;
    step();
    // Registered flag 0, no write: type 00 not taken
    Flag_we = 0; Br_req = 1; Br_type = 2'b00; Br_idx = 3;
    step();
    Br_req = 0;
    checks++;
    if ({Branch_en, FLAG_IN, Flush, Target} !== {3'b100, 10'h1A5}) begin
      failures++;
      $display("FAIL flag_clear_nt got=%h want=%h", {Branch_en, FLAG_IN, Flush, Target}, {3'b100, 10'h1A5});
    end
    step();
    // Same-cycle flag write must be used
    Flag_we = 1; Flag_d = 1; Br_req = 1; Br_type = 2'b00; Br_idx = 3;
    step();
    Flag_we = 0; Br_req = 0;
    checks++;
    if ({Branch_en, FLAG_IN, Flush} !== 3'b111) begin
      failures++;
      $display("FAIL flag_bypass got=%b want=%b", {Branch_en, FLAG_IN, Flush}, 3'b111);
    end
    step();
    step();
  endtask

  task automatic test_back_to_back();
    Lut_we = 1; Lut_waddr = 5; Lut_wdata = 10'h2C3;
    step();
    Lut_we = 0; Br_req = 1; Br_type = 2'b01; Br_idx = 3;
    step();
    checks++;
    if ({Branch_en, FLAG_IN, Flush, Target} !== {3'b100, 10'h1A5}) begin
      failures++;
      $display("FAIL b2b_first got=%h want=%h", {Branch_en, FLAG_IN, Flush, Target}, {3'b100, 10'h1A5});
    end
    Br_idx = 5;
    step();
    checks++;
    if ({Branch_en, FLAG_IN, Flush, Target} !== {3'b100, 10'h2C3}) begin
      failures++;
      $display("FAIL b2b_second got=%h want=%h", {Branch_en, FLAG_IN, Flush, Target}, {3'b100, 10'h2C3});
    end
    // Not-taken resolve followed directly by an always-taken branch
    Br_type = 2'b10; Br_idx = 3;
    step();
    Br_req = 0;
    checks++;
    if ({Branch_en, FLAG_IN, Flush, Target} !== {3'b111, 10'h1A5}) begin
      failures++;
      $display("FAIL b2b_then_taken got=%h want=%h", {Branch_en, FLAG_IN, Flush, Target}, {3'b111, 10'h1A5});
    end
    step();
    step();
    checks++;
    if ({Branch_en, FLAG_IN, Flush} !== 3'b000) begin
      failures++;
      $display("FAIL b2b_settle got=%b want=%b", {Branch_en, FLAG_IN, Flush}, 3'b000);
    end
  endtask

  task automatic test_nop_branch();
    Br_req = 1; Br_type = 2'b11; Br_idx = 5;
    step();
    Br_req = 0;
    checks++;
    if ({Branch_en, FLAG_IN, Flush, Target} !== {3'b100, 10'h2C3}) begin
      failures++;
      $display("FAIL nop_branch got=%h want=%h", {Branch_en, FLAG_IN, Flush, Target}, {3'b100, 10'h2C3});
    end
    step();
  endtask

  task automatic test_wrong_path_ignored();
    Br_req = 1; Br_type = 2'b10; Br_idx = 5;
    step();
    checks++;
    if ({Branch_en, FLAG_IN, Flush, Target} !== {3'b111, 10'h2C3}) begin
      failures++;
      $display("FAIL wp_resolve got=%h want=%h", {Branch_en, FLAG_IN, Flush, Target}, {3'b111, 10'h2C3});
    end
    Br_idx = 3;
    step();
    checks++;
    if ({Branch_en, FLAG_IN, Flush, Target} !== {3'b001, 10'h2C3}) begin
      failures++;
      $display("FAIL wp_flush_ignored got=%h want=%h", {Branch_en, FLAG_IN, Flush, Target}, {3'b001, 10'h2C3});
    end
    step();
    checks++;
    if ({Branch_en, FLAG_IN, Flush, Target} !== {3'b000, 10'h2C3}) begin
      failures++;
      $display("FAIL wp_idle_ignored got=%h want=%h", {Branch_en, FLAG_IN, Flush, Target}, {3'b000, 10'h2C3});
    end
    step();
    Br_req = 0;
    checks++;
    if ({Branch_en, FLAG_IN, Flush, Target} !== {3'b111, 10'h1A5}) begin
      failures++;
      $display("FAIL wp_accept_idle got=%h want=%h", {Branch_en, FLAG_IN, Flush, Target}, {3'b111, 10'h1A5});
    end
    // Halt during the in-flight flush must not cut it short
    Halt = 1;
    step();
    checks++;
    if ({Branch_en, FLAG_IN, Flush} !== 3'b001) begin
      failures++;
      $display("FAIL halt_flush_completes got=%b want=%b", {Branch_en, FLAG_IN, Flush}, 3'b001);
    end
    Halt = 0;
    step();
  endtask

  task automatic test_init_and_halt();
    Br_req = 1; Br_type = 2'b10; Br_idx = 3;
    step();
    Br_req = 0;
    #2;
    Init = 1;
    #1;
    checks++;
    if ({Branch_en, FLAG_IN, Flush, Target} !== 13'h0) begin
      failures++;
      $display("FAIL init_async got=%h want=%h", {Branch_en, FLAG_IN, Flush, Target}, 13'h0);
    end
    step();
    Init = 0;
    step();
    // Flag and table cleared: type 00 at idx 3 is not taken, target 0
    Br_req = 1; Br_type = 2'b00; Br_idx = 3;
    step();
    Br_req = 0;
    checks++;
    if ({Branch_en, FLAG_IN, Flush, Target} !== {3'b100, 10'h000}) begin
      failures++;
      $display("FAIL init_cleared got=%h want=%h", {Branch_en, FLAG_IN, Flush, Target}, {3'b100, 10'h000});
    end
    step();
    Halt = 1; Br_req = 1; Br_type = 2'b10;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({Branch_en, Flush} !== 2'b00) begin
        failures++;
        $display("FAIL halt_blocks cyc=%0d got=%b want=%b", i, {Branch_en, Flush}, 2'b00);
      end
    end
    Halt = 0; Br_req = 0;
    step();
  endtask

  task automatic test_lut_same_cycle();
    Lut_we = 1; Lut_waddr = 3; Lut_wdata = 10'h155;
    Br_req = 1; Br_type = 2'b11; Br_idx = 3;
    step();
    Lut_we = 0;
    checks++;
    if ({Branch_en, FLAG_IN, Flush, Target} !== {3'b100, 10'h000}) begin
      failures++;
      $display("FAIL lut_old_data got=%h want=%h", {Branch_en, FLAG_IN, Flush, Target}, {3'b100, 10'h000});
    end
    step();
    Br_req = 0;
    checks++;
    if ({Branch_en, FLAG_IN, Flush, Target} !== {3'b100, 10'h155}) begin
      failures++;
      $display("FAIL lut_new_data got=%h want=%h", {Branch_en, FLAG_IN, Flush, Target}, {3'b100, 10'h155});
    end
    step();
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    Init = 1;
    step();
    Init = 0;
    checks++;
    if (Taken_cnt !== 16'h0) begin
      failures++;
      $display("FAIL stats_reset got=%h want=%h", Taken_cnt, 16'h0);
    end
    for (int i = 0; i < 5; i++) begin
      Br_req = 1; Br_type = (i < 3) ? 2'b10 : 2'b11;
      step();
      Br_req = 0;
      step();
      step();
    end
    checks++;
    if (Taken_cnt !== 16'd3) begin
      failures++;
      $display("FAIL stats_count got=%h want=%h", Taken_cnt, 16'd3);
    end
    force dut.r_taken_cnt = 16'hFFFF;
    #1;
    release dut.r_taken_cnt;
    Br_req = 1; Br_type = 2'b10;
    step();
    Br_req = 0;
    step();
    step();
    checks++;
    if (Taken_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL stats_saturate got=%h want=%h", Taken_cnt, 16'hFFFF);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_taken_flag();
    test_flag_bypass();
    test_back_to_back();
    test_nop_branch();
    test_wrong_path_ignored();
    test_init_and_halt();
    test_lut_same_cycle();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_branch_unit
`default_nettype wire
